// File: rtl/vga_bounce_box.sv
// vga_bounce_box: box bouncing off the active-area walls, changing colour on every hit.
// Define VGA_BOX_BORDER_EN to draw a 2-pixel white border over everything.
module vga_bounce_box #(
    parameter int          H_ACT    = 640,
    parameter int          V_ACT    = 480,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pause,
    output logic [11:0] pix_data,
    output logic        bounce
);
    localparam logic [0:0] RIGHT = 1'b0, LEFT = 1'b1, DOWN = 1'b0, UP = 1'b1;
    localparam logic [10:0] X_MAX = 11'(H_ACT - BOX_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_ACT - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    logic [10:0] box_x, box_y, sum_x, sum_y, nx_x, nx_y, px, py;
    logic [0:0]  dir_x, dir_y;
    logic [1:0]  ci;
    logic        frame_end, hit_x, hit_y, in_box, blank;
    logic [11:0] box_color, nx_pix;

    always_comb begin
        px = {1'b0, pix_x};
        py = {1'b0, pix_y};
        sum_x = box_x + STEP_W;
        sum_y = box_y + STEP_W;
        hit_x = dir_x == RIGHT ? sum_x >= X_MAX : box_x <= STEP_W;
        hit_y = dir_y == DOWN ? sum_y >= Y_MAX : box_y <= STEP_W;
        // Clamp to the wall on a hit so the position never wraps
        nx_x = dir_x == RIGHT ? (hit_x ? X_MAX : sum_x) : (hit_x ? 11'd0 : box_x - STEP_W);
        nx_y = dir_y == DOWN ? (hit_y ? Y_MAX : sum_y) : (hit_y ? 11'd0 : box_y - STEP_W);
        box_color = ci == 2'd0 ? 12'hF00 : ci == 2'd1 ? 12'h0F0 : ci == 2'd2 ? 12'h00F : 12'hFF0;
        blank = &pix_x | &pix_y;
        in_box = px >= box_x && px < box_x + BOX_W && py >= box_y && py < box_y + BOX_W;
`ifdef VGA_BOX_BORDER_EN
        nx_pix = blank ? 12'h000
               : (px < 11'd2 || px >= 11'(H_ACT - 2) || py < 11'd2 || py >= 11'(V_ACT - 2)) ? 12'hFFF
               : in_box ? box_color : BG_COLOR;
`else
        nx_pix = blank ? 12'h000 : in_box ? box_color : BG_COLOR;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            box_x     <= 11'd0;
            box_y     <= 11'd0;
            dir_x     <= RIGHT;
            dir_y     <= DOWN;
            ci        <= 2'd0;
            pix_data  <= 12'h000;
            bounce    <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            pix_data  <= nx_pix;
            frame_end <= px == 11'(H_ACT - 1) && py == 11'(V_ACT - 1);
            bounce    <= frame_end && !pause && (hit_x || hit_y);
            if (frame_end && !pause) begin
                box_x <= nx_x;
                box_y <= nx_y;
                if (hit_x) dir_x <= ~dir_x;
                if (hit_y) dir_y <= ~dir_y;
                if (hit_x || hit_y) ci <= ci + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_bounce_box.sv
// tb_vga_bounce_box: scoreboard bench for vga_bounce_box with default parameters.
module tb_vga_bounce_box;
    localparam int H = 640, V = 480, B = 32, S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = 10'h3FF;
    logic [9:0]  pix_y = 10'h3FF;
    logic        pause = 1'b0;
    logic [11:0] pix_data;
    logic        bounce;

    vga_bounce_box dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .pause(pause), .pix_data(pix_data), .bounce(bounce)
    );

    always #20 clk = ~clk;

    int errors = 0, checks = 0;
    int mx = 0, my = 0, mdx = 0, mdy = 0, mci = 0;
    logic [11:0] pal [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};
    logic [11:0] q [$];

    function automatic logic [11:0] model_pix(int x, int y);
        if (x == 1023 || y == 1023) return 12'h000;
`ifdef VGA_BOX_BORDER_EN
        if (x < 2 || x >= H - 2 || y < 2 || y >= V - 2) return 12'hFFF;
`endif
        if (x >= mx && x < mx + B && y >= my && y < my + B) return pal[mci];
        return 12'h000;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mdx = 0; mdy = 0; mci = 0;
    endtask

    task automatic model_axis(inout int p, inout int d, input int lim, output bit hit);
        hit = 0;
        if (d == 0) begin
            if (p + S >= lim) begin p = lim; d = 1; hit = 1; end else p = p + S;
        end else begin
            if (p <= S) begin p = 0; d = 0; hit = 1; end else p = p - S;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y);
        pix_x = x[9:0];
        pix_y = y[9:0];
        q.push_back(rst_n ? model_pix(x, y) : 12'h000);
    endtask

    task automatic run_frame(input bit p, input string tag, output bit hx, output bit hy);
        logic [11:0] e;
        hx = 0; hy = 0;
        pause = p;
        drive(H - 1, V - 1);
        tick();
        e = q.pop_front();
        checks++;
        if (pix_data !== e) begin errors++; $display("FAIL %s corner pix_data=%h expected %h", tag, pix_data, e); end
        checks++;
        if (bounce !== 1'b0) begin errors++; $display("FAIL %s pre-update bounce=%b expected 0", tag, bounce); end
        drive(1023, 1023);
        if (!p) begin
            model_axis(mx, mdx, H - B, hx);
            model_axis(my, mdy, V - B, hy);
            if (hx || hy) mci = (mci + 1) % 4;
        end
        tick();
        e = q.pop_front();
        checks++;
        if (pix_data !== e) begin errors++; $display("FAIL %s blank pix_data=%h expected %h", tag, pix_data, e); end
        checks++;
        if (bounce !== (hx || hy)) begin errors++; $display("FAIL %s bounce=%b expected %b", tag, bounce, hx || hy); end
        pause = 1'b0;
    endtask

    task automatic probe_pos(input string tag);
        int px [6], py [6];
        logic [11:0] e;
        px = '{mx, mx + B - 1, mx - 1, mx + B, mx, mx + B - 1};
        py = '{my, my + B - 1, my, my, my - 1, my + B};
        for (int i = 0; i < 6; i++) begin
            drive(px[i] & 1023, py[i] & 1023);
            tick();
            e = q.pop_front();
            checks++;
            if (pix_data !== e) begin
                errors++;
                $display("FAIL %s probe(%0d,%0d) pix_data=%h expected %h", tag, px[i] & 1023, py[i] & 1023, pix_data, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] e;
        int tx [5] = '{5, 40, 5, 0, 1};
        int ty [5] = '{5, 5, 1023, 200, 1};
        rst_n = 1'b0;
        drive(5, 5);
        tick();
        e = q.pop_front();
        checks++;
        if (pix_data !== e) begin errors++; $display("FAIL reset pix_data=%h expected %h", pix_data, e); end
        checks++;
        if (bounce !== 1'b0) begin errors++; $display("FAIL reset bounce=%b expected 0", bounce); end
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(tx[i], ty[i]);
            tick();
            e = q.pop_front();
            checks++;
            if (pix_data !== e) begin
                errors++;
                $display("FAIL pixel(%0d,%0d) pix_data=%h expected %h", tx[i], ty[i], pix_data, e);
            end
        end
    endtask

    task automatic test_x_bounce();
        bit hx, hy;
        for (int f = 1; f <= 304; f++) begin
            run_frame(1'b0, "motion", hx, hy);
            if (f == 3) probe_pos("motion3");
        end
        checks++;
        if (!hx || mdx != 1) begin errors++; $display("FAIL x_wall model hit=%b dir=%0d expected 1/1", hx, mdx); end
        probe_pos("x_wall");
        run_frame(1'b0, "x_after", hx, hy);
        probe_pos("x_after");
    endtask

    task automatic test_pause();
        bit hx, hy;
        for (int f = 0; f < 3; f++) run_frame(1'b1, "paused", hx, hy);
        probe_pos("paused");
        run_frame(1'b0, "resume", hx, hy);
        probe_pos("resume");
    endtask

    task automatic test_corner();
        bit hx = 0, hy = 0;
        int n = 0;
        int c0;
        while (!(hx && hy) && n < 6000) begin
            c0 = mci;
            run_frame(1'b0, "to_corner", hx, hy);
            n++;
        end
        checks++;
        if (!(hx && hy)) begin errors++; $display("FAIL corner not reached after %0d frames", n); end
        checks++;
        if (mci != (c0 + 1) % 4) begin errors++; $display("FAIL corner colour index=%0d expected %0d", mci, (c0 + 1) % 4); end
        probe_pos("corner");
        run_frame(1'b0, "post_corner", hx, hy);
        probe_pos("post_corner");
    endtask

    task automatic test_reset_mid();
        bit hx, hy;
        int n = 0;
        logic [11:0] e;
        while (mx != 100 && n < 700) begin run_frame(1'b0, "to_100", hx, hy); n++; end
        probe_pos("at_100");
        drive(H - 1, V - 1);
        tick();
        e = q.pop_front();
        checks++;
        if (pix_data !== e) begin errors++; $display("FAIL mid corner pix_data=%h expected %h", pix_data, e); end
        rst_n = 1'b0;
        drive(100, 100);
        tick();
        e = q.pop_front();
        checks++;
        if (pix_data !== e) begin errors++; $display("FAIL mid reset pix_data=%h expected %h", pix_data, e); end
        model_reset();
        rst_n = 1'b1;
        drive(1023, 1023);
        tick();
        e = q.pop_front();
        checks++;
        if (bounce !== 1'b0 || pix_data !== e) begin
            errors++;
            $display("FAIL after reset bounce=%b pix_data=%h expected 0/%h", bounce, pix_data, e);
        end
        probe_pos("reset_pos");
        run_frame(1'b0, "first_after_reset", hx, hy);
        probe_pos("first_after_reset");
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        test_reset();
        test_x_bounce();
        test_pause();
        test_corner();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
